mem_ctrl_arb: RTL

//  Responder end of the byte-serial memory interface driven by the IF and MEM stages.

---
 rtl/mem_ctrl_arb_pkg.sv | 31 +++
 rtl/mem_ctrl_arb_if.sv | 42 ++++
 rtl/mem_ctrl_arb.sv | 121 ++++++++++++
 3 files changed

// File: rtl/mem_ctrl_arb_pkg.sv
// mem_ctrl_arb_pkg
//    Shared types and widths for the IF/MEM byte-serial memory arbiter.
//    owner_e : which initiator owns the RAM (OWN_NONE/OWN_IF/OWN_MEM, 2 bits)
//    state_e : arbiter FSM states
//    BYTE_W / REG_W : byte bus and initiator register (address) widths
package mem_ctrl_arb_pkg;

   localparam int BYTE_W = 8;
   localparam int REG_W  = 32;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_MEM  = 2'd2
   } owner_e;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_OWN_IF  = 2'd1,
      ST_OWN_MEM = 2'd2
   } state_e;

   function automatic owner_e state_owner(input state_e s);
      case (s)
         ST_OWN_IF:  return OWN_IF;
         ST_OWN_MEM: return OWN_MEM;
         default:    return OWN_NONE;
      endcase
   endfunction

endpackage

// File: rtl/mem_ctrl_arb_if.sv
// mem_ctrl_arb_if
//    Bus bundle between the IF/MEM initiators, the arbiter and the single-port RAM.
//    slave  : arbiter view (takes requests and RAM read byte, drives grants,
//             read returns and the RAM address/write strobe/write byte)
//    master : environment view (initiators plus RAM), the mirror image
interface mem_ctrl_arb_if #(
   parameter int ADDR_W = 17
);
   import mem_ctrl_arb_pkg::*;

   logic                if_req_i;
   logic [REG_W-1:0]    if_addr_i;
   logic                mem_req_i;
   logic                mem_we_i;
   logic [REG_W-1:0]    mem_addr_i;
   logic [BYTE_W-1:0]   mem_wdata_i;
   logic                if_grant_o;
   logic                mem_grant_o;
   logic [BYTE_W-1:0]   if_rdata_o;
   logic                if_rvalid_o;
   logic [BYTE_W-1:0]   mem_rdata_o;
   logic                mem_rvalid_o;
   logic [ADDR_W-1:0]   ram_addr_o;
   logic                ram_we_o;
   logic [BYTE_W-1:0]   ram_wdata_o;
   logic [BYTE_W-1:0]   ram_rdata_i;

   modport slave (
      input  if_req_i, if_addr_i, mem_req_i, mem_we_i, mem_addr_i, mem_wdata_i,
      input  ram_rdata_i,
      output if_grant_o, mem_grant_o, if_rdata_o, if_rvalid_o,
      output mem_rdata_o, mem_rvalid_o, ram_addr_o, ram_we_o, ram_wdata_o
   );

   modport master (
      output if_req_i, if_addr_i, mem_req_i, mem_we_i, mem_addr_i, mem_wdata_i,
      output ram_rdata_i,
      input  if_grant_o, mem_grant_o, if_rdata_o, if_rvalid_o,
      input  mem_rdata_o, mem_rvalid_o, ram_addr_o, ram_we_o, ram_wdata_o
   );

endinterface

// File: rtl/mem_ctrl_arb.sv
// mem_ctrl_arb
//    Responder end of the byte-serial memory interface shared by IF and MEM.
//    Grants RAM ownership per transaction, forwards the owner's address/write
//    to the RAM and routes the RAM read byte back one cycle later.
// Ports
//    clk   : rising-edge clock
//    rst_n : asynchronous active-low reset
//    bus   : mem_ctrl_arb_if.slave (requests, grants, read returns, RAM side)
// Parameters
//    ADDR_W     : RAM address width; initiator address bits above it are ignored
//    IF_MAXWAIT : cycles IF may wait before it outranks MEM at arbitration (0 = never)
module mem_ctrl_arb
   import mem_ctrl_arb_pkg::*;
#(
   parameter int ADDR_W     = 17,
   parameter int IF_MAXWAIT = 15
) (
   input logic          clk,
   input logic          rst_n,
   mem_ctrl_arb_if.slave bus
);

   localparam int CNT_W = (IF_MAXWAIT > 0) ? $clog2(IF_MAXWAIT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(IF_MAXWAIT);

   state_e             state_q, state_d;
   owner_e             owner, owner_d;
   logic               rd_d;
   logic               rd_now;
   logic               if_wins;
   logic [CNT_W-1:0]   wait_q;
   logic [BYTE_W-1:0]  if_rdata_q, mem_rdata_q;
   logic               unused_addr_hi;

   assign unused_addr_hi = ^{bus.if_addr_i[REG_W-1:ADDR_W], bus.mem_addr_i[REG_W-1:ADDR_W]};

   // IF outranks MEM only when it is requesting and has starved long enough.
   always_comb begin
      if_wins = (IF_MAXWAIT != 0) && bus.if_req_i && (wait_q == CNT_MAX);
   end

   // Reset is folded in so grants and the write strobe fall asynchronously.
   always_comb begin
      state_d = state_q;
      if (!rst_n) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.mem_req_i)
                  state_d = if_wins ? ST_OWN_IF : ST_OWN_MEM;
               else if (bus.if_req_i)
                  state_d = ST_OWN_IF;
            end
            ST_OWN_IF: begin
               if (!bus.if_req_i)
                  state_d = bus.mem_req_i ? ST_OWN_MEM : ST_IDLE;
            end
            ST_OWN_MEM: begin
               if (!bus.mem_req_i)
                  state_d = bus.if_req_i ? ST_OWN_IF : ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Grants and RAM drive follow the next-state owner so the first byte is not delayed.
   always_comb begin
      owner           = state_owner(state_d);
      bus.if_grant_o  = (owner == OWN_IF);
      bus.mem_grant_o = (owner == OWN_MEM);
      bus.ram_addr_o  = '0;
      bus.ram_we_o    = 1'b0;
      bus.ram_wdata_o = '0;
      case (owner)
         OWN_IF: begin
            bus.ram_addr_o = bus.if_addr_i[ADDR_W-1:0];
         end
         OWN_MEM: begin
            bus.ram_addr_o  = bus.mem_addr_i[ADDR_W-1:0];
            bus.ram_we_o    = bus.mem_we_i;
            bus.ram_wdata_o = bus.mem_wdata_i;
         end
         default: ;
      endcase
      rd_now = (owner != OWN_NONE) && !bus.ram_we_o;
   end

   // Routing uses the registered owner, so a byte still returns after req falls.
   always_comb begin
      bus.if_rvalid_o  = rd_d && (owner_d == OWN_IF);
      bus.mem_rvalid_o = rd_d && (owner_d == OWN_MEM);
      bus.if_rdata_o   = bus.if_rvalid_o  ? bus.ram_rdata_i : if_rdata_q;
      bus.mem_rdata_o  = bus.mem_rvalid_o ? bus.ram_rdata_i : mem_rdata_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         owner_d     <= OWN_NONE;
         rd_d        <= 1'b0;
         wait_q      <= '0;
         if_rdata_q  <= '0;
         mem_rdata_q <= '0;
      end else begin
         state_q <= state_d;
         owner_d <= owner;
         rd_d    <= rd_now;
         if (bus.if_grant_o)
            wait_q <= '0;
         else if (bus.if_req_i && (wait_q != CNT_MAX))
            wait_q <= wait_q + CNT_W'(1);
         if (bus.if_rvalid_o)
            if_rdata_q <= bus.ram_rdata_i;
         if (bus.mem_rvalid_o)
            mem_rdata_q <= bus.ram_rdata_i;
      end
   end

endmodule
